// File: rtl/pspin_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// pspin_cmd_dispatcher
//
// Shares the command interfaces (host-direct, NIC outbound, EDMA) among the
// cluster command ports. Cluster commands are round-robin arbitrated and
// routed to the interface named by their intf_id. Interface responses are
// round-robin arbitrated and returned to the owning cluster (the cluster_id
// field at the top of cmd_id). Each cluster has a cap on outstanding commands.
//
// Command word layout (CMD_W bits, LSB first):
//   [CMD_ID_W-1:0]                  cmd_id (cluster_id = top CL_W bits)
//   [CMD_ID_W +: INTF_ID_W]         intf_id
//   [CMD_ID_W+INTF_ID_W]            generate_event
//   [CMD_W-1 -: DATA_W]             payload
// Response word layout (RESP_W bits):
//   [CMD_ID_W-1:0]                  cmd_id (cluster_id = top CL_W bits)
//   [RESP_W-1 -: RESP_DATA_W]       response data
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cl_cmd_valid_i/_ready_o, cl_cmd_i      cluster command ports (flattened)
//   intf_cmd_valid_o/_ready_i, intf_cmd_o  interface command side (shared data)
//   intf_resp_valid_i/_ready_o, intf_resp_i interface response ports (flattened)
//   cl_resp_valid_o, cl_resp_o             one-cycle response pulse to a cluster
//   inflight_o            per-cluster outstanding count (flattened)
//   err_o                 one-cycle pulse on a protocol error
// ---------------------------------------------------------------------------
module pspin_cmd_dispatcher #(
    parameter int NUM_CLUSTERS = 4,
    parameter int NUM_INTF     = 3,
    parameter int MAX_INFLIGHT = 32,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1),
    parameter int CMD_ID_W     = 8,
    parameter int INTF_ID_W    = 2,
    parameter int DATA_W       = 32,
    parameter int RESP_DATA_W  = 16,
    localparam int CMD_W       = DATA_W + 1 + INTF_ID_W + CMD_ID_W,
    localparam int RESP_W      = RESP_DATA_W + CMD_ID_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CLUSTERS-1:0]       cl_cmd_valid_i,
    output logic [NUM_CLUSTERS-1:0]       cl_cmd_ready_o,
    input  logic [NUM_CLUSTERS*CMD_W-1:0] cl_cmd_i,
    output logic [NUM_INTF-1:0]           intf_cmd_valid_o,
    input  logic [NUM_INTF-1:0]           intf_cmd_ready_i,
    output logic [CMD_W-1:0]              intf_cmd_o,
    input  logic [NUM_INTF-1:0]           intf_resp_valid_i,
    output logic [NUM_INTF-1:0]           intf_resp_ready_o,
    input  logic [NUM_INTF*RESP_W-1:0]    intf_resp_i,
    output logic [NUM_CLUSTERS-1:0]       cl_resp_valid_o,
    output logic [RESP_W-1:0]             cl_resp_o,
    output logic [NUM_CLUSTERS*CNT_W-1:0] inflight_o,
    output logic                          err_o
);

    localparam int CL_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int IF_W = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1;

    logic [CMD_W-1:0]        clCmd [NUM_CLUSTERS];
    logic [RESP_W-1:0]       intfResp [NUM_INTF];

    logic [CNT_W-1:0]        inflight_q [NUM_CLUSTERS];
    logic [CNT_W-1:0]        inflight_d [NUM_CLUSTERS];
    logic [CL_W-1:0]         cmdPtr_q, cmdPtr_d;
    logic [IF_W-1:0]         respPtr_q, respPtr_d;
    logic [CMD_W-1:0]        cmd_q, cmd_d;
    logic [NUM_INTF-1:0]     intfValid_q, intfValid_d;
    logic [RESP_W-1:0]       resp_q, resp_d;
    logic [NUM_CLUSTERS-1:0] clRespValid_q, clRespValid_d;
    logic                    err_q, err_d;

    logic [NUM_CLUSTERS-1:0] cmdEligible;
    logic                    cmdDrain;
    logic                    cmdCanLoad;
    logic                    cmdGrantAny;
    logic [CL_W-1:0]         cmdGrantIdx;
    logic [CMD_W-1:0]        selCmd;
    logic [INTF_ID_W-1:0]    selIntfId;
    logic                    selIntfOk;

    logic [NUM_INTF-1:0]     respReq;
    logic                    respGrantAny;
    logic [IF_W-1:0]         respGrantIdx;
    logic [RESP_W-1:0]       selResp;
    logic [CL_W-1:0]         respCluster;
    logic                    respClusterOk;

    // Grants are suppressed while reset is held so that the combinational
    // ready outputs are zero during reset, like the registered ones.
    for (genvar g = 0; g < NUM_CLUSTERS; g++) begin : genCluster
        assign clCmd[g]                        = cl_cmd_i[g*CMD_W +: CMD_W];
        assign inflight_o[g*CNT_W +: CNT_W]    = inflight_q[g];
        assign cmdEligible[g] = cl_cmd_valid_i[g] && !rst_i &&
                                (inflight_q[g] < CNT_W'(MAX_INFLIGHT));
    end

    for (genvar g = 0; g < NUM_INTF; g++) begin : genIntf
        assign intfResp[g] = intf_resp_i[g*RESP_W +: RESP_W];
    end

    assign respReq = intf_resp_valid_i & {NUM_INTF{~rst_i}};

    // The output register may take a new command when empty or when its
    // current content is handed over in this same cycle.
    assign cmdDrain   = |(intfValid_q & intf_cmd_ready_i);
    assign cmdCanLoad = !(|intfValid_q) || cmdDrain;

    // Round-robin command pick: first eligible cluster from cmdPtr_q upward.
    always_comb begin
        logic [CL_W-1:0] cand;
        cand        = '0;
        cmdGrantAny = 1'b0;
        cmdGrantIdx = '0;
        if (cmdCanLoad) begin
            for (int k = 0; k < NUM_CLUSTERS; k++) begin
                cand = CL_W'((int'(cmdPtr_q) + k) % NUM_CLUSTERS);
                if (!cmdGrantAny && cmdEligible[cand]) begin
                    cmdGrantAny = 1'b1;
                    cmdGrantIdx = cand;
                end
            end
        end
    end

    // Round-robin response pick: first valid interface from respPtr_q upward.
    always_comb begin
        logic [IF_W-1:0] cand;
        cand         = '0;
        respGrantAny = 1'b0;
        respGrantIdx = '0;
        for (int k = 0; k < NUM_INTF; k++) begin
            cand = IF_W'((int'(respPtr_q) + k) % NUM_INTF);
            if (!respGrantAny && respReq[cand]) begin
                respGrantAny = 1'b1;
                respGrantIdx = cand;
            end
        end
    end

    assign selCmd        = clCmd[cmdGrantIdx];
    assign selIntfId     = selCmd[CMD_ID_W +: INTF_ID_W];
    assign selIntfOk     = int'(selIntfId) < NUM_INTF;
    assign selResp       = intfResp[respGrantIdx];
    assign respCluster   = selResp[CMD_ID_W-1 -: CL_W];
    assign respClusterOk = int'(respCluster) < NUM_CLUSTERS;

    assign cl_cmd_ready_o    = cmdGrantAny ? (NUM_CLUSTERS'(1) << cmdGrantIdx) : '0;
    assign intf_resp_ready_o = respGrantAny ? (NUM_INTF'(1) << respGrantIdx) : '0;

    // Next-state for both paths. A command with an unknown intf_id is
    // consumed but never reaches an interface and is not counted in flight.
    always_comb begin
        logic inc;
        logic dec;
        inc           = 1'b0;
        dec           = 1'b0;
        cmd_d         = cmd_q;
        intfValid_d   = intfValid_q;
        cmdPtr_d      = cmdPtr_q;
        resp_d        = resp_q;
        clRespValid_d = '0;
        respPtr_d     = respPtr_q;
        err_d         = 1'b0;

        if (cmdDrain) begin
            intfValid_d = '0;
        end
        if (cmdGrantAny) begin
            cmdPtr_d = (int'(cmdGrantIdx) == NUM_CLUSTERS - 1) ? '0 : cmdGrantIdx + CL_W'(1);
            if (selIntfOk) begin
                cmd_d       = selCmd;
                intfValid_d = NUM_INTF'(1) << selIntfId;
            end else begin
                intfValid_d = '0;
                err_d       = 1'b1;
            end
        end

        if (respGrantAny) begin
            respPtr_d = (int'(respGrantIdx) == NUM_INTF - 1) ? '0 : respGrantIdx + IF_W'(1);
            resp_d    = selResp;
            if (respClusterOk) begin
                clRespValid_d = NUM_CLUSTERS'(1) << respCluster;
            end else begin
                err_d = 1'b1;
            end
        end

        // A simultaneous increment and decrement cancel out; a response for
        // an idle cluster is still delivered but flagged.
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            inc = cmdGrantAny && selIntfOk && (int'(cmdGrantIdx) == c);
            dec = respGrantAny && respClusterOk && (int'(respCluster) == c);
            inflight_d[c] = inflight_q[c];
            if (dec && (inflight_q[c] == '0)) begin
                err_d = 1'b1;
            end
            if (inc && !dec) begin
                inflight_d[c] = inflight_q[c] + CNT_W'(1);
            end else if (dec && !inc && (inflight_q[c] != '0)) begin
                inflight_d[c] = inflight_q[c] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmdPtr_q      <= '0;
            respPtr_q     <= '0;
            cmd_q         <= '0;
            intfValid_q   <= '0;
            resp_q        <= '0;
            clRespValid_q <= '0;
            err_q         <= 1'b0;
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                inflight_q[c] <= '0;
            end
        end else begin
            cmdPtr_q      <= cmdPtr_d;
            respPtr_q     <= respPtr_d;
            cmd_q         <= cmd_d;
            intfValid_q   <= intfValid_d;
            resp_q        <= resp_d;
            clRespValid_q <= clRespValid_d;
            err_q         <= err_d;
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                inflight_q[c] <= inflight_d[c];
            end
        end
    end

    assign intf_cmd_valid_o = intfValid_q;
    assign intf_cmd_o       = cmd_q;
    assign cl_resp_valid_o  = clRespValid_q;
    assign cl_resp_o        = resp_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_pspin_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_pspin_cmd_dispatcher
//
// Randomised bench for pspin_cmd_dispatcher. A cycle-level reference model
// keeps per-cluster outstanding counts, the two round-robin pointers, the
// pending interface command and the pending cluster response as plain
// integers, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pspin_cmd_dispatcher;

    localparam int NUM_CLUSTERS = 4;
    localparam int NUM_INTF     = 3;
    localparam int MAX_INFLIGHT = 32;
    localparam int CNT_W        = 6;
    localparam int CMD_ID_W     = 8;
    localparam int INTF_ID_W    = 2;
    localparam int DATA_W       = 32;
    localparam int RESP_DATA_W  = 16;
    localparam int CMD_W        = DATA_W + 1 + INTF_ID_W + CMD_ID_W;
    localparam int RESP_W       = RESP_DATA_W + CMD_ID_W;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_CLUSTERS-1:0]       clCmdValid;
    logic [NUM_CLUSTERS-1:0]       clCmdReady;
    logic [NUM_CLUSTERS*CMD_W-1:0] clCmd;
    logic [NUM_INTF-1:0]           intfCmdValid;
    logic [NUM_INTF-1:0]           intfCmdReady;
    logic [CMD_W-1:0]              intfCmd;
    logic [NUM_INTF-1:0]           intfRespValid;
    logic [NUM_INTF-1:0]           intfRespReady;
    logic [NUM_INTF*RESP_W-1:0]    intfResp;
    logic [NUM_CLUSTERS-1:0]       clRespValid;
    logic [RESP_W-1:0]             clResp;
    logic [NUM_CLUSTERS*CNT_W-1:0] inflight;
    logic                          err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                      mInf [NUM_CLUSTERS];
    int                      mCmdPtr;
    int                      mRespPtr;
    bit                      mPendValid;
    int                      mPendIntf;
    logic [CMD_W-1:0]        mPendCmd;
    logic [NUM_CLUSTERS-1:0] mRespValid;
    logic [RESP_W-1:0]       mResp;
    bit                      mErr;

    always #5 clk = ~clk;

    pspin_cmd_dispatcher #(
        .NUM_CLUSTERS (NUM_CLUSTERS),
        .NUM_INTF     (NUM_INTF),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W),
        .CMD_ID_W     (CMD_ID_W),
        .INTF_ID_W    (INTF_ID_W),
        .DATA_W       (DATA_W),
        .RESP_DATA_W  (RESP_DATA_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .cl_cmd_valid_i    (clCmdValid),
        .cl_cmd_ready_o    (clCmdReady),
        .cl_cmd_i          (clCmd),
        .intf_cmd_valid_o  (intfCmdValid),
        .intf_cmd_ready_i  (intfCmdReady),
        .intf_cmd_o        (intfCmd),
        .intf_resp_valid_i (intfRespValid),
        .intf_resp_ready_o (intfRespReady),
        .intf_resp_i       (intfResp),
        .cl_resp_valid_o   (clRespValid),
        .cl_resp_o         (clResp),
        .inflight_o        (inflight),
        .err_o             (err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CLUSTERS; c++) mInf[c] = 0;
        mCmdPtr    = 0;
        mRespPtr   = 0;
        mPendValid = 1'b0;
        mPendIntf  = 0;
        mPendCmd   = '0;
        mRespValid = '0;
        mResp      = '0;
        mErr       = 1'b0;
    endtask

    // Drive one cycle of random inputs; percentages control traffic mix.
    task automatic applyStimulus(input int cmdPct, input int respPct, input int readyPct, input int badPct);
        logic [CMD_W-1:0]  cmd;
        logic [RESP_W-1:0] resp;
        int                iid;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            clCmdValid[c] = int'($urandom_range(99)) < cmdPct;
            iid = (int'($urandom_range(99)) < badPct) ? 3 : int'($urandom_range(NUM_INTF - 1));
            cmd = {DATA_W'($urandom), 1'($urandom), INTF_ID_W'(iid), CMD_ID_W'($urandom)};
            clCmd[c*CMD_W +: CMD_W] = cmd;
        end
        for (int i = 0; i < NUM_INTF; i++) begin
            intfCmdReady[i]  = int'($urandom_range(99)) < readyPct;
            intfRespValid[i] = int'($urandom_range(99)) < respPct;
            resp = {RESP_DATA_W'($urandom), 2'($urandom_range(NUM_CLUSTERS - 1)), 6'($urandom)};
            intfResp[i*RESP_W +: RESP_W] = resp;
        end
    endtask

    task automatic predict(output int g, output int r);
        bit canLoad;
        int c;
        canLoad = !mPendValid || intfCmdReady[mPendIntf];
        g = -1;
        if (canLoad) begin
            for (int k = 0; k < NUM_CLUSTERS; k++) begin
                c = (mCmdPtr + k) % NUM_CLUSTERS;
                if (g < 0 && clCmdValid[c] && mInf[c] < MAX_INFLIGHT) g = c;
            end
        end
        r = -1;
        for (int k = 0; k < NUM_INTF; k++) begin
            c = (mRespPtr + k) % NUM_INTF;
            if (r < 0 && intfRespValid[c]) r = c;
        end
    endtask

    task automatic checkCycle(input int g, input int r);
        logic [NUM_CLUSTERS*CNT_W-1:0] expInf;
        for (int c = 0; c < NUM_CLUSTERS; c++) expInf[c*CNT_W +: CNT_W] = CNT_W'(mInf[c]);
        checkOutput("clCmdReady", 64'(clCmdReady), (g >= 0) ? 64'(1) << g : 64'(0));
        checkOutput("intfRespReady", 64'(intfRespReady), (r >= 0) ? 64'(1) << r : 64'(0));
        checkOutput("intfCmdValid", 64'(intfCmdValid), mPendValid ? 64'(1) << mPendIntf : 64'(0));
        if (mPendValid) checkOutput("intfCmd", 64'(intfCmd), 64'(mPendCmd));
        checkOutput("clRespValid", 64'(clRespValid), 64'(mRespValid));
        if (mRespValid != '0) checkOutput("clResp", 64'(clResp), 64'(mResp));
        checkOutput("err", 64'(err), 64'(mErr));
        checkOutput("inflight", 64'(inflight), 64'(expInf));
    endtask

    task automatic advance(input int g, input int r);
        bit               inc [NUM_CLUSTERS];
        bit               dec [NUM_CLUSTERS];
        bit               errNext;
        logic [CMD_W-1:0] cmd;
        int               iid;
        int               rc;
        errNext = 1'b0;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            inc[c] = 1'b0;
            dec[c] = 1'b0;
        end
        if (mPendValid && intfCmdReady[mPendIntf]) mPendValid = 1'b0;
        if (g >= 0) begin
            cmd = clCmd[g*CMD_W +: CMD_W];
            iid = int'(cmd[CMD_ID_W +: INTF_ID_W]);
            if (iid < NUM_INTF) begin
                mPendValid = 1'b1;
                mPendIntf  = iid;
                mPendCmd   = cmd;
                inc[g]     = 1'b1;
            end else begin
                errNext = 1'b1;
            end
            mCmdPtr = (g + 1) % NUM_CLUSTERS;
        end
        mRespValid = '0;
        if (r >= 0) begin
            mResp      = intfResp[r*RESP_W +: RESP_W];
            rc         = int'(mResp[CMD_ID_W-1 -: 2]);
            mRespValid = NUM_CLUSTERS'(1) << rc;
            dec[rc]    = 1'b1;
            mRespPtr   = (r + 1) % NUM_INTF;
        end
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            if (dec[c] && mInf[c] == 0) errNext = 1'b1;
            if (inc[c] && !dec[c]) mInf[c] = mInf[c] + 1;
            else if (dec[c] && !inc[c] && mInf[c] > 0) mInf[c] = mInf[c] - 1;
        end
        mErr = errNext;
    endtask

    task automatic stepCycle();
        int g;
        int r;
        @(negedge clk);
        predict(g, r);
        checkCycle(g, r);
        advance(g, r);
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n, input int cmdPct, input int respPct, input int readyPct, input int badPct);
        for (int i = 0; i < n; i++) begin
            applyStimulus(cmdPct, respPct, readyPct, badPct);
            stepCycle();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".clCmdReady"}, 64'(clCmdReady), 64'(0));
        checkOutput({tag, ".intfCmdValid"}, 64'(intfCmdValid), 64'(0));
        checkOutput({tag, ".intfCmd"}, 64'(intfCmd), 64'(0));
        checkOutput({tag, ".intfRespReady"}, 64'(intfRespReady), 64'(0));
        checkOutput({tag, ".clRespValid"}, 64'(clRespValid), 64'(0));
        checkOutput({tag, ".clResp"}, 64'(clResp), 64'(0));
        checkOutput({tag, ".inflight"}, 64'(inflight), 64'(0));
        checkOutput({tag, ".err"}, 64'(err), 64'(0));
    endtask

    initial begin
        logic [NUM_CLUSTERS-1:0] rrExp [5];
        logic [CMD_W-1:0]        cmd;
        int                      g;
        int                      r;
        rrExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst           = 1'b1;
        clCmdValid    = '0;
        clCmd         = '0;
        intfCmdReady  = '0;
        intfRespValid = '0;
        intfResp      = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;

        // All clusters request interface 1 with ready held high.
        for (int i = 0; i < 5; i++) begin
            clCmdValid    = '1;
            intfCmdReady  = '1;
            intfRespValid = '0;
            for (int c = 0; c < NUM_CLUSTERS; c++) begin
                cmd = {DATA_W'($urandom), 1'b0, INTF_ID_W'(1), CMD_ID_W'($urandom)};
                clCmd[c*CMD_W +: CMD_W] = cmd;
            end
            @(negedge clk);
            checkOutput("rrSeq", 64'(clCmdReady), 64'(rrExp[i]));
            predict(g, r);
            checkCycle(g, r);
            advance(g, r);
            @(posedge clk);
            #1;
        end

        // Heavy command load, few responses: drives clusters to the cap.
        runCycles(260, 85, 3, 95, 10);
        // Mixed traffic with back-pressure.
        runCycles(150, 60, 40, 60, 10);

        // Reset mid-burst with busy inputs.
        applyStimulus(90, 60, 90, 0);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("midReset");
        @(posedge clk);
        #1;
        checkAllZero("heldReset");
        rst = 1'b0;
        modelReset();

        runCycles(120, 70, 30, 70, 10);
        // Response-heavy drain, including responses for idle clusters.
        runCycles(150, 20, 70, 80, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
